fallthrough_small_fifo: RTL and testbench
=========================================

// Module: fallthrough_small_fifo
// PURPOSE
//  Small synchronous first-word-fall-through FIFO. The head entry is always
//  presented on dout while empty=0; rd_en pops it, and the next entry appears
//  on the following cycle with no extra read latency. Used for shallow
//  result/metadata queues, e.g. checksum/TTL results awaiting the forwarding
//  process.
// PARAMETERS
//  WIDTH                72             data width in bits
//  MAX_DEPTH_BITS       3              log2 of depth; MAX_DEPTH = 2**MAX_DEPTH_BITS
//  PROG_FULL_THRESHOLD  MAX_DEPTH-1    occupancy at or above which prog_full=1
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  din          in   WIDTH   write data
//  wr_en        in   1       write strobe; din is captured on this edge
//  rd_en        in   1       pop strobe; consumes the word currently on dout
//  dout         out  WIDTH   head-of-queue data, valid when empty=0
//  full         out  1       occupancy == MAX_DEPTH
//  nearly_full  out  1       occupancy >= MAX_DEPTH-1
//  prog_full    out  1       occupancy >= PROG_FULL_THRESHOLD
//  empty        out  1       no word visible on dout
// BEHAVIOUR
//  - Reset (reset=1 at clk edge): occupancy=0, read/write pointers=0,
//    empty=1, full=0, nearly_full=0, prog_full=0, dout=0. Reset wins over
//    wr_en/rd_en in the same cycle, and contents are discarded mid-operation.
//  - Storage: MAX_DEPTH x WIDTH array. Pointers are MAX_DEPTH_BITS wide and
//    wrap modulo MAX_DEPTH. Occupancy counter is MAX_DEPTH_BITS+1 wide.
//  - Write: wr_en=1 and full=0 -> store din at wr_ptr and increment wr_ptr.
//  - Write while full: word dropped, state unchanged; simulation-only
//    $display error with %m and $time (synthesis translate_off).
//  - Read: rd_en=1 and empty=0 -> advance rd_ptr; dout shows the next entry
//    the following cycle, or holds its last value if now empty.
//  - Read while empty: ignored, state unchanged; simulation-only $display
//    error.
//  - Fall-through latency: a word written at edge N into an empty FIFO gives
//    empty=0 and dout=din after edge N. Data is never visible in the same
//    cycle as its write.
//  - Simultaneous wr_en and rd_en:
//    * 0 < occupancy < MAX_DEPTH: both execute, occupancy unchanged.
//    * empty: the read is ignored and the write executes.
//    * full: both execute (pop the head, accept din), occupancy stays
//      MAX_DEPTH, and no error is reported.
//  - Flags are combinational decodes of the registered occupancy:
//    * empty = (occ==0)
//    * full = (occ==MAX_DEPTH)
//    * nearly_full = (occ>=MAX_DEPTH-1)
//    * prog_full = (occ>=PROG_FULL_THRESHOLD)
//  - dout is driven from a register, or from the array indexed by registered
//    rd_ptr; it must be stable for the whole cycle. Ordering is strict FIFO.
//  - No other handshakes. Callers must only assert rd_en when empty=0 and
//    should honour full.
// TESTING
//  1 Reset then idle: empty=1, full=0, nearly_full=0, prog_full=0, dout=0.
//  2 WIDTH=29, MAX_DEPTH_BITS=2: write 0x1,0x2,0x3 on consecutive cycles ->
//    after 1st edge dout=0x1/empty=0; after 3rd edge nearly_full=1, full=0;
//    pop 3x -> dout 0x1,0x2,0x3, then empty=1.
//  3 Fill 4 words -> full=1. 5th write 0xAA is dropped with an error message;
//    drain gives words 1..4 only.
//  4 occ=2, wr_en=rd_en=1 for 6 cycles with 0x10..0x15 -> occ stays 2;
//    output order preserved across pointer wrap.
//  5 Empty FIFO, wr_en=rd_en=1 with din=0x7 -> next cycle empty=0, dout=0x7,
//    occ=1.
//  6 occ=3, assert reset together with wr_en -> next cycle empty=1, occ=0,
//    and the written word is not retained.

Source files
------------

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: shallow first-word-fall-through FIFO.
// The head word is held in a dedicated output register. dout therefore stays
// stable for the whole cycle, and it keeps its last value once the queue
// drains. The flags are decoded from the registered occupancy count.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH               = 72,
  parameter int unsigned MAX_DEPTH_BITS      = 3,
  parameter int unsigned PROG_FULL_THRESHOLD = (2**MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int unsigned MAX_DEPTH = 2**MAX_DEPTH_BITS;
  localparam int unsigned OCC_W     = MAX_DEPTH_BITS + 1;

  localparam logic [OCC_W-1:0]          OCC_FULL   = OCC_W'(MAX_DEPTH);
  localparam logic [OCC_W-1:0]          OCC_NEARLY = OCC_W'(MAX_DEPTH - 1);
  localparam logic [OCC_W-1:0]          OCC_ONE    = OCC_W'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE    = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_succ;
  logic [OCC_W-1:0]          occ;
  logic                      do_write;
  logic                      do_read;

  // Flag decode from the registered occupancy.
  always_comb begin
    empty       = (occ == '0);
    full        = (occ == OCC_FULL);
    nearly_full = (occ >= OCC_NEARLY);
    prog_full   = (32'(occ) >= PROG_FULL_THRESHOLD);
  end

  // Qualify the strobes. A write while full is accepted only when the head is
  // popped in the same cycle. Reset suppresses both operations.
  always_comb begin
    do_read     = !reset && rd_en && !empty;
    do_write    = !reset && wr_en && (!full || rd_en);
    rd_ptr_succ = rd_ptr + PTR_ONE;
  end

  // Pointers and occupancy. The pointers wrap naturally modulo MAX_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read)  rd_ptr <= rd_ptr_succ;
      unique case ({do_write, do_read})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Storage array, written at wr_ptr. It needs no reset because contents are
  // only ever observed through the dout register.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= din;
  end

  // Head register. On a pop, load the successor entry if one remains. If the
  // popped word was the last, a simultaneous write becomes the new head.
  // Otherwise the old value is held. A write into an empty queue falls
  // straight through. When full with write+pop, wr_ptr equals rd_ptr, so the
  // overwrite lands on the slot being vacated and never on rd_ptr_succ.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (do_read) begin
      if (occ > OCC_ONE) dout <= mem[rd_ptr_succ];
      else if (do_write) dout <= din;
    end else if (do_write && empty) begin
      dout <= din;
    end
  end

`ifndef SYNTHESIS
  // Report caller protocol violations in simulation. The hardware ignores them.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && full && !rd_en)
      $display("%m: error: write while full, word dropped at time %0t", $time);
    if (!reset && rd_en && empty)
      $display("%m: error: read while empty ignored at time %0t", $time);
  end
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// Directed bench for fallthrough_small_fifo using a queue-based reference model.
module tb_fallthrough_small_fifo;

  localparam int unsigned W     = 29;
  localparam int unsigned DBITS = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PFT   = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] dout;
  logic         full, nearly_full, prog_full, empty;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last_head = '0;

  fallthrough_small_fifo #(
    .WIDTH(W),
    .MAX_DEPTH_BITS(DBITS),
    .PROG_FULL_THRESHOLD(PFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .dout(dout),
    .full(full),
    .nearly_full(nearly_full),
    .prog_full(prog_full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: pop first if anything is queued, then accept the write
  // if there is room. The visible head is the queue front, or the last head
  // shown once the queue is empty.
  task automatic model_update(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    if (r) begin
      q.delete();
      last_head = '0;
    end else begin
      if (rd && q.size() != 0) void'(q.pop_front());
      if (w && q.size() < DEPTH) q.push_back(d);
      if (q.size() != 0) last_head = q[0];
    end
  endtask

  // Compare every output against the model.
  task automatic compare();
    int n;
    n = q.size();
    check("empty",       32'(empty),       32'(n == 0));
    check("full",        32'(full),        32'(n == DEPTH));
    check("nearly_full", 32'(nearly_full), 32'(n >= DEPTH - 1));
    check("prog_full",   32'(prog_full),   32'(n >= PFT));
    check("dout",        32'(dout),        32'(last_head));
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    reset = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    model_update(r, w, rd, d);
    #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    compare();
  endtask

  initial begin
    // 1: reset, then idle
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_dout",  32'(dout),  32'd0);
    check("t1_full",  32'(full),  32'd0);

    // 2: three writes, then three pops
    step(0, 1, 0, 29'h1);
    check("t2_dout_first",  32'(dout),  32'h1);
    check("t2_empty_first", 32'(empty), 32'd0);
    step(0, 1, 0, 29'h2);
    check("t2_prog_full_occ2", 32'(prog_full), 32'd1);
    step(0, 1, 0, 29'h3);
    check("t2_nearly_full", 32'(nearly_full), 32'd1);
    check("t2_not_full",    32'(full),        32'd0);
    for (int i = 1; i <= 3; i++) begin
      check("t2_pop_head", 32'(dout), 32'(i));
      step(0, 0, 1, '0);
    end
    check("t2_drained_empty", 32'(empty), 32'd1);
    check("t2_drained_hold",  32'(dout),  32'h3);

    // 3: fill, drop a write while full, then drain
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 29'(i));
    check("t3_full", 32'(full), 32'd1);
    step(0, 1, 0, 29'hAA);
    check("t3_still_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain_head", 32'(dout), 32'(i));
      step(0, 0, 1, '0);
    end
    check("t3_empty", 32'(empty), 32'd1);

    // 4: occupancy 2, then simultaneous write+pop across the pointer wrap
    step(0, 1, 0, 29'hA);
    step(0, 1, 0, 29'hB);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 29'(32'h10 + i));
    check("t4_head", 32'(dout),      32'h14);
    check("t4_occ2", 32'(prog_full), 32'd1);
    check("t4_not_nearly", 32'(nearly_full), 32'd0);
    step(0, 0, 1, '0);
    check("t4_second", 32'(dout), 32'h15);
    step(0, 0, 1, '0);

    // 5: simultaneous write+pop into an empty FIFO
    step(0, 1, 1, 29'h7);
    check("t5_empty", 32'(empty), 32'd0);
    check("t5_dout",  32'(dout),  32'h7);
    step(0, 0, 1, '0);

    // full plus simultaneous write+pop keeps the FIFO full and pops the head
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 29'(i));
    step(0, 1, 1, 29'h20);
    check("tf_full", 32'(full), 32'd1);
    check("tf_head", 32'(dout), 32'h2);
    // last entry popped while a new word arrives: the new word becomes the head
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    check("tf_last", 32'(dout), 32'h20);
    step(0, 1, 1, 29'h33);
    check("tf_refill", 32'(dout), 32'h33);
    check("tf_refill_empty", 32'(empty), 32'd0);
    step(0, 0, 1, '0);

    // 6: reset with a concurrent write at occupancy 3
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 29'(i));
    step(1, 1, 0, 29'h55);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_dout",  32'(dout),  32'd0);
    step(0, 0, 0, '0);
    check("t6_stays_empty", 32'(empty), 32'd1);

    // mixed traffic checked against the model
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 29'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
